hazard_stall_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline. Detects load-use and ID-branch

---
 rtl/hazard_stall_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipe: load-use and ID-branch operand hazards,
// branch/jump redirects, memory-busy freeze, saturating event counters and a busy watchdog.
module hazard_stall_ctrl #(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             ID_Branch,
   input  logic             ID_Taken,
   input  logic             ID_Jump,
   input  logic             EX_MemRead,
   input  logic             EX_RegWrite,
   input  logic [4:0]       EX_WriteReg,
   input  logic             MEM_MemRead,
   input  logic [4:0]       MEM_WriteReg,
   input  logic             Mem_Busy,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             Pipe_Freeze,
   output logic [1:0]       State,
   output logic [CNT_W-1:0] Stall_Count,
   output logic [CNT_W-1:0] Flush_Count,
   output logic             Timeout_Err
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_HAZARD   = 2'd1,
      ST_FREEZE   = 2'd2,
      ST_REDIRECT = 2'd3
   } act_t;

   act_t             act_d, state_q;
   logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
   logic [15:0]      busy_q, busy_d;
   logic [16:0]      busy_inc;
   logic             tout_q, tout_d;
   logic             match_ex, match_mem, branch_like, haz_lu, haz_br;

   // Register 0 is hardwired, so a write to it can never create a dependence.
   assign match_ex  = (EX_WriteReg != 5'd0) &&
                      ((ID_UsesRs && EX_WriteReg == ID_Rs) || (ID_UsesRt && EX_WriteReg == ID_Rt));
   assign match_mem = (MEM_WriteReg != 5'd0) &&
                      ((ID_UsesRs && MEM_WriteReg == ID_Rs) || (ID_UsesRt && MEM_WriteReg == ID_Rt));

   // jr/jalr read Rs in ID just like a compare-in-ID branch.
   assign branch_like = ID_Branch || (ID_Jump && ID_UsesRs);
   assign haz_lu      = EX_MemRead && match_ex;
   assign haz_br      = branch_like && ((EX_RegWrite && match_ex) || (MEM_MemRead && match_mem));

   always_comb begin
      act_d       = ST_RUN;
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      Pipe_Freeze = 1'b0;
      if (Rst) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
      end else if (Mem_Busy) begin
         act_d       = ST_FREEZE;
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         Pipe_Freeze = 1'b1;
      end else if (haz_lu || haz_br) begin
         act_d       = ST_HAZARD;
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
      end else if ((ID_Branch && ID_Taken) || ID_Jump) begin
         act_d       = ST_REDIRECT;
         IF_ID_Flush = 1'b1;
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if ((act_d == ST_HAZARD || act_d == ST_FREEZE) && !(&stall_q))
         stall_d = stall_q + CNT_W'(1);
      if (act_d == ST_REDIRECT && !(&flush_q))
         flush_d = flush_q + CNT_W'(1);
   end

   // busy_inc is the count this busy cycle reaches; the flag sets on the same edge.
   assign busy_inc = {1'b0, busy_q} + 17'd1;
   assign busy_d   = !Mem_Busy ? 16'd0 : (&busy_q) ? busy_q : busy_inc[15:0];
   assign tout_d   = tout_q || (Mem_Busy && busy_inc >= 17'(TIMEOUT));

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_RUN;
         stall_q <= '0;
         flush_q <= '0;
         busy_q  <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= act_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
         busy_q  <= busy_d;
         tout_q  <= tout_d;
      end
   end

   assign State       = state_q;
   assign Stall_Count = stall_q;
   assign Flush_Count = flush_q;
   assign Timeout_Err = tout_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized + scenario bench for hazard_stall_ctrl against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 4;
   localparam int CMAX    = (1 << CNT_W) - 1;

   logic             Clk = 1'b0;
   logic             Rst;
   logic [4:0]       ID_Rs, ID_Rt, EX_WriteReg, MEM_WriteReg;
   logic             ID_UsesRs, ID_UsesRt, ID_Branch, ID_Taken, ID_Jump;
   logic             EX_MemRead, EX_RegWrite, MEM_MemRead, Mem_Busy;
   logic             PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, Pipe_Freeze;
   logic [1:0]       State;
   logic [CNT_W-1:0] Stall_Count, Flush_Count;
   logic             Timeout_Err;

   int checks = 0;
   int errors = 0;
   int m_state = 0, m_stall = 0, m_flush = 0, m_busy = 0, m_tout = 0;

   always #5 Clk = ~Clk;

   hazard_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .Clk(Clk), .Rst(Rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt), .ID_Branch(ID_Branch),
      .ID_Taken(ID_Taken), .ID_Jump(ID_Jump), .EX_MemRead(EX_MemRead),
      .EX_RegWrite(EX_RegWrite), .EX_WriteReg(EX_WriteReg), .MEM_MemRead(MEM_MemRead),
      .MEM_WriteReg(MEM_WriteReg), .Mem_Busy(Mem_Busy), .PC_Write(PC_Write),
      .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
      .Pipe_Freeze(Pipe_Freeze), .State(State), .Stall_Count(Stall_Count),
      .Flush_Count(Flush_Count), .Timeout_Err(Timeout_Err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit reads(input logic [4:0] r);
      return (r != 0) && ((ID_UsesRs && r == ID_Rs) || (ID_UsesRt && r == ID_Rt));
   endfunction

   // Action for the current inputs: 0 run, 1 hazard, 2 freeze, 3 redirect.
   function automatic int action();
      bit lu, br;
      lu = EX_MemRead && reads(EX_WriteReg);
      br = (ID_Branch || (ID_Jump && ID_UsesRs)) &&
           ((EX_RegWrite && reads(EX_WriteReg)) || (MEM_MemRead && reads(MEM_WriteReg)));
      if (Mem_Busy)                        return 2;
      if (lu || br)                        return 1;
      if ((ID_Branch && ID_Taken) || ID_Jump) return 3;
      return 0;
   endfunction

   // One clock: check combinational outputs, advance model at the edge, check registered state.
   task automatic step();
      int a;
      #1;
      a = Rst ? -1 : action();
      chk("PC_Write",    32'(PC_Write),    32'(a == 0 || a == 3));
      chk("IF_ID_Write", 32'(IF_ID_Write), 32'(a == 0 || a == 3));
      chk("IF_ID_Flush", 32'(IF_ID_Flush), 32'(a == 3));
      chk("ID_EX_Flush", 32'(ID_EX_Flush), 32'(a == 1));
      chk("Pipe_Freeze", 32'(Pipe_Freeze), 32'(a == 2));
      @(posedge Clk);
      if (Rst) begin
         m_state = 0; m_stall = 0; m_flush = 0; m_busy = 0; m_tout = 0;
      end else begin
         m_state = a;
         if (a == 1 || a == 2) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
         if (a == 3)           m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
         m_busy = Mem_Busy ? m_busy + 1 : 0;
         if (Mem_Busy && m_busy >= TIMEOUT) m_tout = 1;
      end
      #1;
      chk("State",       32'(State),       32'(m_state));
      chk("Stall_Count", 32'(Stall_Count), 32'(m_stall));
      chk("Flush_Count", 32'(Flush_Count), 32'(m_flush));
      chk("Timeout_Err", 32'(Timeout_Err), 32'(m_tout));
   endtask

   task automatic idle();
      Rst = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0; ID_Branch = 0;
      ID_Taken = 0; ID_Jump = 0; EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0;
      MEM_MemRead = 0; MEM_WriteReg = 0; Mem_Busy = 0;
   endtask

   task automatic do_reset();
      idle(); Rst = 1; step(); Rst = 0;
   endtask

   initial begin
      int busy_left;
      idle();
      do_reset();

      // Load-use: lw $8 in EX, add reads $8 in ID.
      ID_Rs = 8; ID_UsesRs = 1; EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 8;
      step();
      chk("lu_state", 32'(State), 32'd1);
      idle(); step();
      chk("lu_stall", 32'(Stall_Count), 32'd1);

      // lw $8 then beq $8: two hazard cycles, then the taken redirect.
      do_reset();
      ID_Rs = 8; ID_UsesRs = 1; ID_Branch = 1; ID_Taken = 1;
      EX_MemRead = 1; EX_RegWrite = 1; EX_WriteReg = 8; step();
      EX_MemRead = 0; EX_RegWrite = 0; EX_WriteReg = 0; MEM_MemRead = 1; MEM_WriteReg = 8; step();
      MEM_MemRead = 0; MEM_WriteReg = 0; step();
      chk("lb_stall", 32'(Stall_Count), 32'd2);
      chk("lb_flush", 32'(Flush_Count), 32'd1);

      // Plain jump redirects.
      idle(); ID_Jump = 1; step(); idle(); step();

      // Freeze over a load-use hazard for 3 cycles, then one hazard cycle.
      do_reset();
      ID_Rs = 8; ID_UsesRs = 1; EX_MemRead = 1; EX_WriteReg = 8; Mem_Busy = 1;
      repeat (3) step();
      Mem_Busy = 0; step();
      chk("fz_stall", 32'(Stall_Count), 32'd4);
      idle(); step();

      // Watchdog: 6 busy cycles, flag stays set after busy drops, clears on reset.
      do_reset();
      Mem_Busy = 1; repeat (6) step();
      Mem_Busy = 0; repeat (2) step();
      chk("wd_sticky", 32'(Timeout_Err), 32'd1);

      // Register 0 never hazards; reset mid-freeze.
      do_reset();
      EX_MemRead = 1; EX_WriteReg = 0; ID_Rs = 0; ID_UsesRs = 1; step();
      chk("r0_nostall", 32'(Stall_Count), 32'd0);
      idle(); Mem_Busy = 1; repeat (2) step();
      Rst = 1; step(); Rst = 0; Mem_Busy = 0; step();

      // Saturation: drive many hazards past the counter maximum.
      ID_Rs = 3; ID_UsesRs = 1; EX_MemRead = 1; EX_WriteReg = 3;
      repeat (CMAX + 4) step();
      chk("sat_stall", 32'(Stall_Count), 32'(CMAX));
      idle(); ID_Jump = 1; repeat (CMAX + 4) step();
      chk("sat_flush", 32'(Flush_Count), 32'(CMAX));

      // Randomized traffic with small register set and busy bursts.
      idle(); busy_left = 0;
      for (int i = 0; i < 600; i++) begin
         Rst          = ($urandom_range(0, 59) == 0);
         ID_Rs        = 5'($urandom_range(0, 3));
         ID_Rt        = 5'($urandom_range(0, 3));
         ID_UsesRs    = 1'($urandom);
         ID_UsesRt    = 1'($urandom);
         ID_Branch    = ($urandom_range(0, 2) == 0);
         ID_Taken     = 1'($urandom);
         ID_Jump      = ($urandom_range(0, 5) == 0);
         EX_MemRead   = ($urandom_range(0, 2) == 0);
         EX_RegWrite  = 1'($urandom);
         EX_WriteReg  = 5'($urandom_range(0, 3));
         MEM_MemRead  = ($urandom_range(0, 2) == 0);
         MEM_WriteReg = 5'($urandom_range(0, 3));
         if (busy_left == 0 && $urandom_range(0, 7) == 0) busy_left = $urandom_range(1, 7);
         Mem_Busy = (busy_left != 0);
         if (busy_left != 0) busy_left--;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
